// File: rtl/lc3b_types.sv
// Shared types for the LC-3b instruction cache: line/word types, address field widths
// and the fill controller state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [2:0]   lc3b_c_offset;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [8:0]   lc3b_c_tag;

    // Address bits above the 16-byte line offset, i.e. {tag, index}.
    localparam int unsigned LineAddrW = 12;
    localparam int unsigned LineOffW  = 4;

    typedef enum logic {
        StIdle,
        StFill
    } icache_state_e;

endpackage

// File: rtl/icache_control.sv
// IDLE/FILL controller for the instruction cache: latches the missing line address and
// holds the physical-memory read request until the line arrives.
module icache_control
    import lc3b_types::*;
#(
    parameter int unsigned LineW = LineAddrW
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_read,
    input  logic                           hit,
    input  logic [LineW-1:0]               req_line,
    input  logic                           pmem_resp,
    output logic                           idle,
    output logic                           load,
    output logic [LineW-1:0]               fill_line,
    output logic                           pmem_read,
    output logic [LineW+LineOffW-1:0]      pmem_address
);

    icache_state_e    state_q;
    logic [LineW-1:0] line_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            line_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_read && !hit) begin
                        state_q <= StFill;
                        line_q  <= req_line;
                    end
                end
                StFill: begin
                    if (pmem_resp) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset gates the request immediately so memory drops an in-flight fill.
    assign pmem_read    = (state_q == StFill) && !reset;
    assign pmem_address = pmem_read ? {line_q, {LineOffW{1'b0}}} : '0;
    assign idle         = (state_q == StIdle) && !reset;
    assign load         = pmem_read && pmem_resp;
    assign fill_line    = line_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: valid/tag/data arrays, tag compare and word
// select; hits answer combinationally in the request cycle.
module icache
    import lc3b_types::*;
#(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    input  logic [127:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int unsigned IndexW = $clog2(NUM_SETS);
    localparam int unsigned TagW   = LineAddrW - IndexW;

    logic [NUM_SETS-1:0] valid_q;
    logic [TagW-1:0]     tag_q  [NUM_SETS];
    lc3b_line            data_q [NUM_SETS];

    lc3b_c_offset        offset;
    logic [IndexW-1:0]   index;
    logic [TagW-1:0]     tag;
    logic [LineAddrW-1:0] fill_line;
    logic [IndexW-1:0]   fill_index;
    logic [TagW-1:0]     fill_tag;
    logic                hit;
    logic                idle;
    logic                load;
    logic                unused_addr_bit;

    // Bit 0 is a byte select within the 16-bit word and plays no part in lookup.
    assign unused_addr_bit = mem_address[0];

    assign offset     = mem_address[3:1];
    assign index      = mem_address[LineOffW +: IndexW];
    assign tag        = mem_address[15 -: TagW];
    assign fill_index = fill_line[IndexW-1:0];
    assign fill_tag   = fill_line[LineAddrW-1 -: TagW];

    assign hit       = mem_read && valid_q[index] && (tag_q[index] == tag);
    assign mem_resp  = idle && hit;
    assign mem_rdata = data_q[index][{offset, 4'b0000} +: 16];

    icache_control #(
        .LineW (LineAddrW)
    ) u_control (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .hit          (hit),
        .req_line     (mem_address[15:LineOffW]),
        .pmem_resp    (pmem_resp),
        .idle         (idle),
        .load         (load),
        .fill_line    (fill_line),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (load) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // Tag and data are deliberately left out of reset; valid bits gate them.
    always_ff @(posedge clk) begin
        if (load) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: an address-arithmetic cache model is compared every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_icache;

    localparam int Sets    = 8;
    localparam int Latency = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    icache #(
        .NUM_SETS (Sets)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: per set a valid flag, the cached line number and its eight words.
    bit m_valid [Sets];
    int m_line  [Sets];
    int m_word  [Sets][8];
    bit m_fill;
    int m_fill_line;
    int m_fill_cnt;
    bit stray;

    // Sampled DUT outputs of the most recent cycle, for literal pins.
    logic        s_resp;
    logic [15:0] s_rdata;
    logic        s_pread;
    logic [15:0] s_paddr;

    function automatic logic [15:0] line_word(int line, int i);
        if (line == 0) return 16'(16'h1111 * (i + 1));
        return 16'(((line * 8 + i) * 257) ^ 16'h5A5A);
    endfunction

    function automatic logic [127:0] line_data(int line);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[16*i +: 16] = line_word(line, i);
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(int addr);
        int line = addr / 16;
        return m_valid[line % Sets] && (m_line[line % Sets] == line);
    endfunction

    // One clock cycle: responder, compare at negedge, model update at posedge.
    task automatic tick();
        bit exp_pread, exp_resp;
        int exp_paddr;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (m_fill && m_fill_cnt == Latency - 1) begin
            pmem_resp  = 1'b1;
            pmem_rdata = line_data(m_fill_line);
        end else if (stray) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {8{16'hDEAD}};
        end
        @(negedge clk);
        exp_pread = m_fill && !reset;
        exp_paddr = exp_pread ? m_fill_line * 16 : 0;
        exp_resp  = !reset && !m_fill && mem_read && model_hit(int'(mem_address));
        chk("pmem_read", 32'(pmem_read), 32'(exp_pread));
        chk("pmem_address", 32'(pmem_address), 32'(exp_paddr));
        chk("mem_resp", 32'(mem_resp), 32'(exp_resp));
        if (exp_resp) begin
            chk("mem_rdata", 32'(mem_rdata),
                32'(m_word[(mem_address / 16) % Sets][(mem_address / 2) % 8]));
        end
        s_resp  = mem_resp;
        s_rdata = mem_rdata;
        s_pread = pmem_read;
        s_paddr = pmem_address;
        @(posedge clk);
        if (reset) begin
            m_fill = 1'b0;
            for (int s = 0; s < Sets; s++) m_valid[s] = 1'b0;
        end else if (m_fill) begin
            m_fill_cnt++;
            if (pmem_resp) begin
                m_valid[m_fill_line % Sets] = 1'b1;
                m_line[m_fill_line % Sets]  = m_fill_line;
                for (int i = 0; i < 8; i++) m_word[m_fill_line % Sets][i] = line_word(m_fill_line, i);
                m_fill = 1'b0;
            end
        end else if (mem_read && !model_hit(int'(mem_address))) begin
            m_fill      = 1'b1;
            m_fill_line = int'(mem_address) / 16;
            m_fill_cnt  = 0;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [15:0] a);
        mem_read    = 1'b1;
        mem_address = a;
        tick();
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_address = '0; stray = 1'b0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        m_fill = 1'b0; m_fill_line = 0; m_fill_cnt = 0;
        for (int s = 0; s < Sets; s++) begin
            m_valid[s] = 1'b0; m_line[s] = -1;
            for (int i = 0; i < 8; i++) m_word[s][i] = 0;
        end
        #1;
        run(2);
        chk("reset_pmem_addr", 32'(s_paddr), 32'h0);
        chk("reset_resp", 32'(s_resp), 32'h0);
        reset = 1'b0;

        // Cold miss then hit.
        rd(16'h0000);
        chk("cold_miss", 32'(s_resp), 32'h0);
        tick();
        chk("cold_fill_read", 32'(s_pread), 32'h1);
        chk("cold_fill_addr", 32'(s_paddr), 32'h0000);
        run(2);
        tick();
        chk("cold_hit_resp", 32'(s_resp), 32'h1);
        chk("cold_hit_data", 32'(s_rdata), 32'h1111);
        rd(16'h0006);
        chk("word3_resp", 32'(s_resp), 32'h1);
        chk("word3_data", 32'(s_rdata), 32'h4444);
        chk("word3_no_fill", 32'(s_pread), 32'h0);

        // Conflict on set 0.
        rd(16'h0080);
        chk("conflict_miss", 32'(s_resp), 32'h0);
        tick();
        chk("conflict_fill_addr", 32'(s_paddr), 32'h0080);
        run(2);
        tick();
        chk("conflict_hit", 32'(s_resp), 32'h1);
        rd(16'h0000);
        chk("evicted_miss", 32'(s_resp), 32'h0);
        run(3);
        tick();
        chk("refill_hit", 32'(s_rdata), 32'h1111);

        // Redirect during fill.
        rd(16'h0010);
        tick();
        mem_address = 16'h0200;
        tick();
        chk("redirect_addr_held", 32'(s_paddr), 32'h0010);
        chk("redirect_no_resp", 32'(s_resp), 32'h0);
        tick();
        chk("redirect_addr_resp", 32'(s_paddr), 32'h0010);
        tick();
        chk("redirect_new_miss", 32'(s_resp), 32'h0);
        tick();
        chk("redirect_new_fill", 32'(s_paddr), 32'h0200);
        run(2);
        rd(16'h0010);
        chk("redirect_old_hit", 32'(s_resp), 32'h1);

        // Reset mid-fill.
        rd(16'h0030);
        tick();
        reset = 1'b1;
        tick();
        chk("reset_mid_pread", 32'(s_pread), 32'h0);
        chk("reset_mid_resp", 32'(s_resp), 32'h0);
        tick();
        reset = 1'b0;
        rd(16'h0000);
        chk("post_reset_miss", 32'(s_resp), 32'h0);
        run(3);
        tick();
        chk("post_reset_hit", 32'(s_resp), 32'h1);

        // Idle with stray responses.
        mem_read = 1'b0;
        stray = 1'b1;
        tick();
        chk("stray_resp", 32'(s_resp), 32'h0);
        chk("stray_pread", 32'(s_pread), 32'h0);
        tick();
        stray = 1'b0;
        rd(16'h0020);
        chk("stray_no_install", 32'(s_resp), 32'h0);
        run(3);

        // Odd address returns containing word.
        rd(16'h0003);
        chk("odd_resp", 32'(s_resp), 32'h1);
        chk("odd_data", 32'(s_rdata), 32'h2222);

        mem_read = 1'b0;
        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
